apb_req_master: RTL and testbench

- Upstream APB master stage. Converts a simple valid/ready request/response interface into APB4 transfers. Its APB side feeds an APB demultiplexer, whose default port is the APB error slave.
- Drives one APB transfer at a time using a SETUP/ACCESS state machine.
- Buffers a single response.
- Has an optional watchdog that aborts transfers stalled by a slave that never raises pready, so a misdecoded or hung slave cannot lock up the requester.

---
 rtl/apb_req_master.sv | 134 +++++++++++++
 tb/tb_apb_req_master.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_master.sv
// Upstream APB4 master: turns a valid/ready request into one SETUP/ACCESS transfer
// and holds a single response, with an optional watchdog for slaves that never respond.
module apb_req_master #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 0,
  parameter logic [31:0] TimeoutData   = 32'hDEADBEEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic                   req_write_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [DataWidth/8-1:0] req_strb_i,
  input  logic [2:0]             req_prot_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic                   rsp_err_o,
  output logic [AddrWidth-1:0]   paddr_o,
  output logic [2:0]             pprot_o,
  output logic                   psel_o,
  output logic                   penable_o,
  output logic                   pwrite_o,
  output logic [DataWidth-1:0]   pwdata_o,
  output logic [DataWidth/8-1:0] pstrb_o,
  input  logic                   pready_i,
  input  logic [DataWidth-1:0]   prdata_i,
  input  logic                   pslverr_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam logic [15:0] TimeoutLast =
      (TimeoutCycles == 0) ? 16'd0 : 16'(TimeoutCycles - 1);
  localparam logic [DataWidth-1:0] TimeoutValue = TimeoutData[DataWidth-1:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [15:0] wait_cnt_r;
  logic        timeout_s;

  // The counter holds the number of ACCESS cycles already spent waiting,
  // so it equals N-1 during the N-th ACCESS cycle.
  assign timeout_s   = (TimeoutCycles != 0) && !pready_i && (wait_cnt_r == TimeoutLast);
  assign req_ready_o = rst_ni && (state_r == IDLE);

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid_i) state_s = SETUP;
        else             state_s = IDLE;
      end
      SETUP: state_s = ACCESS;
      ACCESS: begin
        if (pready_i || timeout_s) state_s = RESP;
        else                       state_s = ACCESS;
      end
      RESP: begin
        if (rsp_ready_i) state_s = IDLE;
        else             state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register plus APB/response strobes registered from the next state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      rsp_valid_o <= 1'b0;
    end else begin
      state_r     <= state_s;
      psel_o      <= (state_s == SETUP) || (state_s == ACCESS);
      penable_o   <= (state_s == ACCESS);
      rsp_valid_o <= (state_s == RESP);
    end
  end

  // Request capture, watchdog counter and response capture.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      paddr_o     <= {AddrWidth{1'b0}};
      pprot_o     <= 3'b000;
      pwrite_o    <= 1'b0;
      pwdata_o    <= {DataWidth{1'b0}};
      pstrb_o     <= {StrbWidth{1'b0}};
      rsp_rdata_o <= {DataWidth{1'b0}};
      rsp_err_o   <= 1'b0;
      wait_cnt_r  <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid_i) begin
            paddr_o  <= req_addr_i;
            pprot_o  <= req_prot_i;
            pwrite_o <= req_write_i;
            pwdata_o <= req_wdata_i;
            pstrb_o  <= req_write_i ? req_strb_i : {StrbWidth{1'b0}};
          end
        end
        SETUP: wait_cnt_r <= 16'd0;
        ACCESS: begin
          if (pready_i) begin
            rsp_rdata_o <= pwrite_o ? {DataWidth{1'b0}} : prdata_i;
            rsp_err_o   <= pslverr_i;
          end else if (timeout_s) begin
            rsp_rdata_o <= pwrite_o ? {DataWidth{1'b0}} : TimeoutValue;
            rsp_err_o   <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        RESP: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_master.sv
// Directed bench for apb_req_master with a 4-cycle watchdog; the APB slave is
// driven step by step and every check is an immediate assertion.
module tb_apb_req_master;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_strb_i;
  logic [2:0]  req_prot_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic [31:0] paddr_o, pwdata_o, prdata_i;
  logic [2:0]  pprot_o;
  logic        psel_o, penable_o, pwrite_o, pready_i, pslverr_i;
  logic [3:0]  pstrb_o;

  int n_cmp = 0;
  int n_bad = 0;

  apb_req_master #(
    .AddrWidth(32), .DataWidth(32), .TimeoutCycles(4), .TimeoutData(32'hDEADBEEF)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_write_i(req_write_i), .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
    .req_prot_i(req_prot_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o),
    .paddr_o(paddr_o), .pprot_o(pprot_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [3:0] strb, input logic [2:0] prot);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_write_i = wr;
    req_wdata_i = wd;
    req_strb_i  = strb;
    req_prot_i  = prot;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rsp_valid"}, {63'd0, rsp_valid_o}, 64'd0);
    chk({tag, "_req_ready"}, {63'd0, req_ready_o}, 64'd1);
    chk({tag, "_psel"},      {63'd0, psel_o},      64'd0);
  endtask

  initial begin
    rst_ni = 1'b0;
    req_valid_i = 1'b0; req_addr_i = 32'd0; req_write_i = 1'b0;
    req_wdata_i = 32'd0; req_strb_i = 4'd0; req_prot_i = 3'd0;
    rsp_ready_i = 1'b0; pready_i = 1'b0; prdata_i = 32'd0; pslverr_i = 1'b0;

    // reset state
    step(); step();
    chk("rst_psel",      {63'd0, psel_o},      64'd0);
    chk("rst_penable",   {63'd0, penable_o},   64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    chk("rst_req_ready", {63'd0, req_ready_o}, 64'd0);
    chk("rst_paddr",     {32'd0, paddr_o},     64'd0);
    rst_ni = 1'b1;
    #1;
    chk("idle_req_ready", {63'd0, req_ready_o}, 64'd1);

    // read, zero wait
    request(32'h0000_0010, 1'b0, 32'd0, 4'h0, 3'b010);
    pready_i = 1'b1; prdata_i = 32'h1234_5678;
    step();
    req_valid_i = 1'b0;
    chk("rd_setup_psel",    {63'd0, psel_o},      64'd1);
    chk("rd_setup_penable", {63'd0, penable_o},   64'd0);
    chk("rd_setup_paddr",   {32'd0, paddr_o},     64'h10);
    chk("rd_setup_pprot",   {61'd0, pprot_o},     64'd2);
    chk("rd_setup_pwrite",  {63'd0, pwrite_o},    64'd0);
    chk("rd_setup_ready",   {63'd0, req_ready_o}, 64'd0);
    step();
    chk("rd_access_psel",    {63'd0, psel_o},    64'd1);
    chk("rd_access_penable", {63'd0, penable_o}, 64'd1);
    step();
    chk("rd_resp_psel",    {63'd0, psel_o},      64'd0);
    chk("rd_resp_penable", {63'd0, penable_o},   64'd0);
    chk("rd_resp_valid",   {63'd0, rsp_valid_o}, 64'd1);
    chk("rd_resp_rdata",   {32'd0, rsp_rdata_o}, 64'h1234_5678);
    chk("rd_resp_err",     {63'd0, rsp_err_o},   64'd0);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    chk_idle("rd_done");

    // write with 3 wait states, ready in the 4th ACCESS cycle (watchdog boundary)
    request(32'h0000_0020, 1'b1, 32'hA5A5_A5A5, 4'h3, 3'b000);
    pready_i = 1'b0; prdata_i = 32'h5555_5555;
    step();
    req_valid_i = 1'b0; req_addr_i = 32'hFFFF_FFFF; req_wdata_i = 32'h0;
    chk("wr_setup_pstrb",  {60'd0, pstrb_o},  64'h3);
    chk("wr_setup_pwdata", {32'd0, pwdata_o}, 64'hA5A5_A5A5);
    chk("wr_setup_pwrite", {63'd0, pwrite_o}, 64'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wr_wait%0d_penable", i), {63'd0, penable_o}, 64'd1);
      chk($sformatf("wr_wait%0d_paddr", i),   {32'd0, paddr_o},   64'h20);
      chk($sformatf("wr_wait%0d_pwdata", i),  {32'd0, pwdata_o},  64'hA5A5_A5A5);
      chk($sformatf("wr_wait%0d_pstrb", i),   {60'd0, pstrb_o},   64'h3);
      if (i < 3) step();
      else pready_i = 1'b1;
    end
    step();
    chk("wr_resp_valid", {63'd0, rsp_valid_o}, 64'd1);
    chk("wr_resp_rdata", {32'd0, rsp_rdata_o}, 64'd0);
    chk("wr_resp_err",   {63'd0, rsp_err_o},   64'd0);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    chk_idle("wr_done");

    // read to the error slave; strobes must be dropped for a read
    request(32'h0000_0030, 1'b0, 32'd0, 4'hF, 3'b000);
    pready_i = 1'b1; prdata_i = 32'hBADC_AB1E; pslverr_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    chk("err_setup_pstrb", {60'd0, pstrb_o}, 64'd0);
    step();
    step();
    chk("err_resp_valid", {63'd0, rsp_valid_o}, 64'd1);
    chk("err_resp_err",   {63'd0, rsp_err_o},   64'd1);
    chk("err_resp_rdata", {32'd0, rsp_rdata_o}, 64'hBADC_AB1E);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    chk_idle("err_done");

    // timeout on a read; junk on prdata/pslverr must be ignored while pready=0
    request(32'h0000_0040, 1'b0, 32'd0, 4'h0, 3'b000);
    pready_i = 1'b0; prdata_i = 32'h1111_1111; pslverr_i = 1'b0;
    step();
    req_valid_i = 1'b0;
    step(); step(); step(); step();
    chk("to_cycle4_penable", {63'd0, penable_o},   64'd1);
    chk("to_cycle4_valid",   {63'd0, rsp_valid_o}, 64'd0);
    step();
    chk("to_resp_psel",    {63'd0, psel_o},      64'd0);
    chk("to_resp_penable", {63'd0, penable_o},   64'd0);
    chk("to_resp_valid",   {63'd0, rsp_valid_o}, 64'd1);
    chk("to_resp_err",     {63'd0, rsp_err_o},   64'd1);
    chk("to_resp_rdata",   {32'd0, rsp_rdata_o}, 64'hDEAD_BEEF);

    // backpressure: response held 5 cycles with a new request waiting
    request(32'h0000_0050, 1'b0, 32'd0, 4'h0, 3'b001);
    pready_i = 1'b1; prdata_i = 32'h0BAD_F00D;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp%0d_req_ready", i), {63'd0, req_ready_o}, 64'd0);
      chk($sformatf("bp%0d_valid", i),     {63'd0, rsp_valid_o}, 64'd1);
      chk($sformatf("bp%0d_rdata", i),     {32'd0, rsp_rdata_o}, 64'hDEAD_BEEF);
      chk($sformatf("bp%0d_err", i),       {63'd0, rsp_err_o},   64'd1);
      chk($sformatf("bp%0d_psel", i),      {63'd0, psel_o},      64'd0);
    end
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    chk_idle("bp_done");
    step();
    req_valid_i = 1'b0;
    chk("bp_next_psel",  {63'd0, psel_o},  64'd1);
    chk("bp_next_paddr", {32'd0, paddr_o}, 64'h50);
    chk("bp_next_pprot", {61'd0, pprot_o}, 64'd1);
    step();
    step();
    chk("bp_next_rdata", {32'd0, rsp_rdata_o}, 64'h0BAD_F00D);
    chk("bp_next_err",   {63'd0, rsp_err_o},   64'd0);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;

    // reset during an ACCESS wait state
    request(32'h0000_0060, 1'b0, 32'd0, 4'h0, 3'b000);
    pready_i = 1'b0;
    step();
    req_valid_i = 1'b0;
    step(); step();
    chk("mr_pre_penable", {63'd0, penable_o}, 64'd1);
    rst_ni = 1'b0;
    step();
    chk("mr_psel",      {63'd0, psel_o},      64'd0);
    chk("mr_penable",   {63'd0, penable_o},   64'd0);
    chk("mr_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    chk("mr_req_ready", {63'd0, req_ready_o}, 64'd0);
    rst_ni = 1'b1;
    request(32'h0000_0070, 1'b0, 32'd0, 4'h0, 3'b000);
    pready_i = 1'b1; prdata_i = 32'hCAFE_0001;
    #1;
    chk("mr_after_ready", {63'd0, req_ready_o}, 64'd1);
    step();
    req_valid_i = 1'b0;
    chk("mr_new_psel",  {63'd0, psel_o},  64'd1);
    chk("mr_new_paddr", {32'd0, paddr_o}, 64'h70);
    step();
    chk("mr_new_penable", {63'd0, penable_o}, 64'd1);
    step();
    chk("mr_new_valid", {63'd0, rsp_valid_o}, 64'd1);
    chk("mr_new_rdata", {32'd0, rsp_rdata_o}, 64'hCAFE_0001);
    chk("mr_new_err",   {63'd0, rsp_err_o},   64'd0);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    chk_idle("mr_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
